// File: rtl/mem_burst_responder_pkg.sv
// mem_burst_responder_pkg: state encoding and default line geometry shared with the cache.
package mem_burst_responder_pkg;
  typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RBURST} state_e;
  localparam int MEM_DATA_BITS_DEF = 128;
  localparam int BEATS_DEF = 4;
endpackage

// File: rtl/mem_burst_responder_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), advances every cycle, async active-low reset to SEED.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] lfsr_o
);
  logic [7:0] lfsr_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: main-memory model serving line write bursts and fixed-latency read bursts.
// Define MEM_BURST_RESPONDER_STALL_EN to gate the request/data ready signals with an LFSR.
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
  parameter int MEM_ADDR_BITS = 28,
  parameter int BEATS         = BEATS_DEF,
  parameter int DEPTH_LOG2    = 12,
  parameter int READ_LATENCY  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_val,
  output logic                       mem_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  input  logic                       mem_req_rw,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_val,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);
  localparam int NB = MEM_DATA_BITS / 8;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [DEPTH_LOG2-1:0] LINE_MASK = ~DEPTH_LOG2'(BEATS - 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [LW-1:0] LAT_END = LW'(READ_LATENCY - 2);
  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   base_q, base_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [MEM_DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic [MEM_DATA_BITS-1:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   wr_addr, rd_addr;
  logic                    gate, req_fire, wr_fire;
  logic                    unused_addr;
`ifdef MEM_BURST_RESPONDER_STALL_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;
  lfsr8 #(.SEED(8'hA5)) u_lfsr (.clk_i(clk), .rst_ni(reset), .lfsr_o(lfsr));
  assign gate = lfsr[0] & reset;
  assign unused_lfsr = ^lfsr[7:1];
`else
  assign gate = 1'b1;
`endif
  assign unused_addr = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];
  assign mem_req_rdy = (state_q == IDLE) & gate;
  assign mem_req_data_ready = (state_q == WDATA) & gate;
  assign mem_resp_val = state_q == RBURST;
  assign mem_resp_data = resp_data_q;
  assign req_fire = mem_req_val & mem_req_rdy;
  assign wr_fire = mem_req_data_valid & mem_req_data_ready;
  assign wr_addr = base_q | DEPTH_LOG2'(cnt_q);
  // Response data is fetched one cycle ahead from the next-state beat index so the output is a flop.
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    case (state_q)
      IDLE: if (req_fire) begin
        base_d = mem_req_addr[DEPTH_LOG2-1:0] & LINE_MASK;
        cnt_d = '0;
        lat_d = '0;
        state_d = mem_req_rw ? WDATA : (READ_LATENCY == 1 ? RBURST : RWAIT);
      end
      WDATA: if (wr_fire) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? IDLE : WDATA;
      end
      RWAIT: begin
        lat_d = lat_q + 1'b1;
        state_d = lat_q == LAT_END ? RBURST : RWAIT;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? IDLE : RBURST;
      end
    endcase
    rd_addr = base_d | DEPTH_LOG2'(cnt_d);
    resp_data_d = state_d == RBURST ? mem_q[rd_addr] : resp_data_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      lat_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      resp_data_q <= resp_data_d;
    end
  always_ff @(posedge clk)
    if (wr_fire)
      for (int b = 0; b < NB; b++)
        if (mem_req_data_mask[b]) mem_q[wr_addr][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: randomized bench; expected read beats go to a scoreboard queue checked by a monitor.
module tb_mem_burst_responder;
  localparam int DW = 128, AW = 28, BEATS = 4, D = 12, L = 4, NB = DW / 8;
`ifdef MEM_BURST_RESPONDER_STALL_EN
  localparam logic RST_RDY = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic mem_req_val = 1'b0, mem_req_rdy, mem_req_rw = 1'b0;
  logic mem_req_data_valid = 1'b0, mem_req_data_ready, mem_resp_val;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data_bits = '0, mem_resp_data;
  logic [NB-1:0] mem_req_data_mask = '0;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {logic [DW-1:0] d; int c;} exp_t;
  exp_t sb[$];
  logic [DW-1:0] model [2**D];
  bit known [2**D];
  bit line_known [2**D/BEATS];
  int lines[$];
  logic [DW-1:0] wd [BEATS];
  logic [NB-1:0] wm [BEATS];

  mem_burst_responder #(
    .MEM_DATA_BITS(DW), .MEM_ADDR_BITS(AW), .BEATS(BEATS), .DEPTH_LOG2(D), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (reset && mem_resp_val) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got beat %h, required no beat (cycle %0d)", mem_resp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", mem_resp_data, e.d);
        chk("resp_cycle", DW'(cyc), DW'(e.c));
      end
    end

  task automatic req(input logic rw, input logic [AW-1:0] a, output int n);
    mem_req_val = 1'b1;
    mem_req_rw = rw;
    mem_req_addr = a;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (mem_req_rdy) begin
        n = cyc;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: mem_req_rdy stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    mem_req_val = 1'b0;
  endtask

  task automatic wait_dready();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (mem_req_data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL data_ready_timeout: mem_req_data_ready stayed 0, required 1");
    end
  endtask

  task automatic wr_line(input logic [AW-1:0] a, input int gap);
    int n, base;
    bit all;
    base = int'(a[D-1:0]) & ~(BEATS - 1);
    req(1'b1, a, n);
    for (int b = 0; b < BEATS; b++) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_bits = wd[b];
      mem_req_data_mask = wm[b];
      wait_dready();
      @(posedge clk);
      #1;
      mem_req_data_valid = 1'b0;
      for (int k = 0; k < NB; k++)
        if (wm[b][k]) model[base+b][8*k +: 8] = wd[b][8*k +: 8];
      if (wm[b] == '1) known[base+b] = 1'b1;
      if (b < BEATS - 1)
        repeat (gap) begin
          @(negedge clk);
          chk("rdy_low_in_write_gap", DW'(mem_req_rdy), DW'(0));
          @(posedge clk);
          #1;
        end
    end
    all = 1'b1;
    for (int b = 0; b < BEATS; b++) all &= known[base+b];
    if (all && !line_known[base/BEATS]) begin
      line_known[base/BEATS] = 1'b1;
      lines.push_back(base);
    end
`ifndef MEM_BURST_RESPONDER_STALL_EN
    if (gap == 0) begin
      @(negedge clk);
      chk("wr_rdy_return_cycles", DW'(cyc - n), DW'(BEATS + 1));
      chk("wr_rdy_high", DW'(mem_req_rdy), DW'(1));
      @(posedge clk);
      #1;
    end
`endif
  endtask

  task automatic rd_line(input logic [AW-1:0] a);
    int n, base;
    exp_t e;
    base = int'(a[D-1:0]) & ~(BEATS - 1);
    req(1'b0, a, n);
    for (int b = 0; b < BEATS; b++) begin
      e.d = model[base+b];
      e.c = n + L + b;
      sb.push_back(e);
    end
    do @(negedge clk); while (cyc < n + L + BEATS - 1);
`ifndef MEM_BURST_RESPONDER_STALL_EN
    chk("rd_rdy_busy", DW'(mem_req_rdy), DW'(0));
    chk("rd_dready_low", DW'(mem_req_data_ready), DW'(0));
`endif
    @(negedge clk);
`ifndef MEM_BURST_RESPONDER_STALL_EN
    chk("rd_rdy_return", DW'(mem_req_rdy), DW'(1));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n, ln;
    bit lk;
    logic [AW-1:0] a;
    #2 reset = 1'b0;
    #1;
    chk("reset_rdy", DW'(mem_req_rdy), DW'(RST_RDY));
    chk("reset_dready", DW'(mem_req_data_ready), DW'(0));
    chk("reset_resp_val", DW'(mem_resp_val), DW'(0));
    chk("reset_resp_data", mem_resp_data, DW'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
`ifndef MEM_BURST_RESPONDER_STALL_EN
    @(negedge clk);
    chk("post_reset_rdy", DW'(mem_req_rdy), DW'(1));
`endif
    @(posedge clk);
    #1;
    // full-mask write then read with a non-aligned address
    for (int b = 0; b < BEATS; b++) begin
      wd[b] = DW'(b + 1);
      wm[b] = '1;
    end
    wr_line(AW'('h10), 0);
    rd_line(AW'('h13));
    // single-byte masked write
    for (int b = 0; b < BEATS; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom};
      wm[b] = '0;
    end
    wd[0] = DW'('hFF);
    wm[0] = NB'(1);
    wr_line(AW'('h10), 0);
    rd_line(AW'('h10));
    // gapped write beats
    for (int b = 0; b < BEATS; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom};
      wm[b] = '1;
    end
    wr_line(AW'('h20), 2);
    rd_line(AW'('h20));
    // upper address bits alias onto the same storage
    for (int b = 0; b < BEATS; b++) wd[b] = {$urandom, $urandom, $urandom, $urandom};
    wr_line(AW'('h1000), 0);
    rd_line(AW'('h0));
    // reset in the middle of a read burst
    req(1'b0, AW'('h10), n);
    for (int b = 0; b < BEATS; b++) begin
      exp_t e;
      e.d = model['h10+b];
      e.c = n + L + b;
      sb.push_back(e);
    end
    do @(negedge clk); while (cyc < n + L + 2);
    #2 reset = 1'b0;
    #1;
    chk("midburst_reset_resp_val", DW'(mem_resp_val), DW'(0));
    chk("midburst_reset_resp_data", mem_resp_data, DW'(0));
    chk("midburst_reset_rdy", DW'(mem_req_rdy), DW'(RST_RDY));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
`ifndef MEM_BURST_RESPONDER_STALL_EN
    chk("midburst_release_rdy", DW'(mem_req_rdy), DW'(1));
`endif
    chk("midburst_release_val", DW'(mem_resp_val), DW'(0));
    @(posedge clk);
    #1;
    rd_line(AW'('h10));
    // randomized write/read pairs
    for (int i = 0; i < 24; i++) begin
      ln = int'($urandom_range(0, 15)) * BEATS;
      lk = line_known[ln/BEATS];
      for (int b = 0; b < BEATS; b++) begin
        wd[b] = {$urandom, $urandom, $urandom, $urandom};
        wm[b] = lk ? NB'({$urandom, $urandom}) : '1;
      end
      a = AW'($urandom);
      a[D-1:0] = D'(ln) | D'($urandom_range(0, BEATS - 1));
      wr_line(a, int'($urandom_range(0, 2)));
      a = AW'($urandom);
      a[D-1:0] = D'(lines[$urandom_range(0, lines.size() - 1)]) | D'($urandom_range(0, BEATS - 1));
      rd_line(a);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", DW'(sb.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
